// File: rtl/pow_sched_pkg.sv
// Shared types and helpers for the exponentiation scheduler.
package pow_sched_pkg;

  typedef enum logic [1:0] {IDLE, STEP, DONE} state_t;

  // Multiplicative identity that seeds the accumulator at the start of a job.
  localparam int unsigned ONE = 1;

  // Widest request vector rr_pick can search.
  localparam int unsigned MAX_CLIENT = 32;

  // Round-robin pick: first set bit of req, searching from rr+1 upward with wrap.
  // rr itself is checked last, so a client that was just served goes behind the others.
  function automatic int unsigned rr_pick(input logic [MAX_CLIENT-1:0] req,
                                          input int unsigned rr,
                                          input int unsigned nclient);
    int unsigned idx;
    logic        found;
    rr_pick = rr;
    found   = 1'b0;
    for (int unsigned i = 1; i <= MAX_CLIENT; i++) begin
      if (i <= nclient && !found) begin
        idx = rr + i;
        if (idx >= nclient) idx = idx - nclient;
        if (req[idx[4:0]]) begin
          rr_pick = idx;
          found   = 1'b1;
        end
      end
    end
  endfunction

endpackage

// File: rtl/mult_w.sv
// Combinational W-bit multiplier; the product keeps only its low W bits.
module mult_w #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] o
);

  // Context width W truncates the product to the low W bits.
  assign o = a * b;

endmodule

// File: rtl/pow_scheduler.sv
// Round-robin scheduler sharing one multiplier between NCLIENT x**n requesters.
// Each job runs square-and-multiply on the shared multiplier, one use per cycle.
module pow_scheduler
  import pow_sched_pkg::*;
#(
  parameter int unsigned NCLIENT = 4,
  parameter int unsigned W       = 16,
  parameter int unsigned NW      = 8
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [NCLIENT-1:0]    req,
  input  logic [NCLIENT*W-1:0]  x_in,
  input  logic [NCLIENT*NW-1:0] n_in,
  output logic [NCLIENT-1:0]    ack,
  output logic [NCLIENT-1:0]    done,
  output logic [W-1:0]          result,
  output logic                  busy
);

  localparam int unsigned CW = (NCLIENT > 1) ? $clog2(NCLIENT) : 1;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CW-1:0]       r_rr;
  logic [CW-1:0]       r_owner;
  logic [CW-1:0]       w_grant;
  logic [W-1:0]        r_acc;
  logic [W-1:0]        r_base;
  logic [W-1:0]        r_result;
  logic [W-1:0]        w_mul_a;
  logic [W-1:0]        w_mul_b;
  logic [W-1:0]        w_prod;
  logic [NW-1:0]       r_pw;
  logic [NCLIENT-1:0]  r_ack;
  logic [NCLIENT-1:0]  r_done;
  logic                w_start;
  logic                w_finish;

  // The single shared multiplier; operand selection stays in this module.
  mult_w #(.W(W)) u_mult (
    .a (w_mul_a),
    .b (w_mul_b),
    .o (w_prod)
  );

  // Next state, grant choice and multiplier operand mux.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_finish    = 1'b0;
    w_grant     = CW'(rr_pick(MAX_CLIENT'(req), 32'(r_rr), NCLIENT));
    // Odd remaining exponent: multiply step acc*base, otherwise square step base*base.
    w_mul_a     = r_pw[0] ? r_acc : r_base;
    w_mul_b     = r_base;
    case (r_state)
      IDLE: begin
        if (|req) begin
          w_start     = 1'b1;
          w_state_nxt = STEP;
        end
      end
      STEP: begin
        if (r_pw == '0) begin
          w_finish    = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Control state: FSM, round-robin pointer, handshake pulses and published result.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state  <= IDLE;
      r_rr     <= '0;
      r_ack    <= '0;
      r_done   <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ack   <= '0;
      r_done  <= '0;
      if (w_start) begin
        r_ack[w_grant] <= 1'b1;
        r_rr           <= w_grant;
      end
      if (w_finish) begin
        r_done[r_owner] <= 1'b1;
        r_result        <= r_acc;
      end
    end
  end

  // Job datapath: operand capture on grant, then one square or multiply per STEP cycle.
  always_ff @(posedge clk) begin
    if (w_start) begin
      r_acc   <= W'(ONE);
      r_base  <= x_in[w_grant*W +: W];
      r_pw    <= n_in[w_grant*NW +: NW];
      r_owner <= w_grant;
    end else if (r_state == STEP && r_pw != '0) begin
      if (r_pw[0]) begin
        r_acc   <= w_prod;
        r_pw[0] <= 1'b0;
      end else begin
        r_base <= w_prod;
        r_pw   <= r_pw >> 1;
      end
    end
  end

  assign ack    = r_ack;
  assign done   = r_done;
  assign result = r_result;
  assign busy   = (r_state != IDLE);

endmodule

// File: tb/tb_pow_scheduler.sv
// Bench for pow_scheduler: directed scenarios then randomized jobs against a behavioural model.
module tb_pow_scheduler;

  localparam int NCLIENT = 4;
  localparam int W       = 16;
  localparam int NW      = 8;

  logic                  clk = 1'b0;
  logic                  nrst;
  logic [NCLIENT-1:0]    req;
  logic [NCLIENT*W-1:0]  x_in;
  logic [NCLIENT*NW-1:0] n_in;
  logic [NCLIENT-1:0]    ack;
  logic [NCLIENT-1:0]    done;
  logic [W-1:0]          result;
  logic                  busy;

  int checks = 0;
  int errors = 0;
  int model_rr = 0;
  logic job_open = 1'b0;
  logic [W-1:0] xs [NCLIENT];
  int           ns [NCLIENT];

  pow_scheduler #(.NCLIENT(NCLIENT), .W(W), .NW(NW)) dut (
    .clk    (clk),
    .nrst   (nrst),
    .req    (req),
    .x_in   (x_in),
    .n_in   (n_in),
    .ack    (ack),
    .done   (done),
    .result (result),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: x**n mod 2**W by repeated multiplication.
  function automatic logic [W-1:0] ref_pow(input logic [W-1:0] x, input int n);
    logic [W-1:0] r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * x;
    return r;
  endfunction

  // Reference: cycles spent in STEP.
  function automatic int lat_of(input int n);
    int b;
    int m;
    if (n == 0) return 1;
    b = 0;
    m = n;
    while (m > 0) begin
      b++;
      m = m >> 1;
    end
    return $countones(n) + b;
  endfunction

  // Reference: round-robin choice among pending requests.
  function automatic int pick(input logic [NCLIENT-1:0] r, input int rr);
    for (int i = 1; i <= NCLIENT; i++) begin
      int idx;
      idx = (rr + i) % NCLIENT;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    chk("onehot", ($onehot0(ack) && $onehot0(done) && !(|ack && |done)) ? 1 : 0, 1);
    if (|ack) chk("ack_during_job", job_open, 0);
  endtask

  task automatic set_ops(input int k, input logic [W-1:0] x, input int n);
    xs[k] = x;
    ns[k] = n;
    x_in[k*W +: W]   = x;
    n_in[k*NW +: NW] = NW'(n);
  endtask

  task automatic wait_ack(output int g);
    g = -1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ack != 0) begin
        for (int k = 0; k < NCLIENT; k++) if (ack[k]) g = k;
        break;
      end
    end
    chk("ack_seen", (g >= 0) ? 1 : 0, 1);
  endtask

  task automatic wait_done(output int g, output int lat);
    g = -1;
    lat = 0;
    for (int i = 0; i < 600; i++) begin
      tick();
      lat++;
      if (done != 0) begin
        for (int k = 0; k < NCLIENT; k++) if (done[k]) g = k;
        break;
      end
    end
    chk("done_seen", (g >= 0) ? 1 : 0, 1);
  endtask

  // Serve the next pending request: check grant, result and latency.
  task automatic serve(input bit drop);
    int e;
    int g;
    int gd;
    int lat;
    e = pick(req, model_rr);
    wait_ack(g);
    chk("ack_grant", 32'(ack), 32'(1) << e);
    if (drop) req[e] = 1'b0;
    model_rr = e;
    if (g >= 0) job_open = 1'b1;
    wait_done(gd, lat);
    job_open = 1'b0;
    chk("done_owner", 32'(done), 32'(1) << e);
    chk("result", 32'(result), 32'(ref_pow(xs[e], ns[e])));
    chk("latency", lat, lat_of(ns[e]));
  endtask

  task automatic run_job(input int k, input logic [W-1:0] x, input int n);
    set_ops(k, x, n);
    req[k] = 1'b1;
    serve(1);
    tick();
    chk("idle_busy", busy, 0);
    chk("result_hold", 32'(result), 32'(ref_pow(x, n)));
  endtask

  initial begin
    int g;
    logic seen;
    nrst = 1'b0;
    req  = '0;
    x_in = '0;
    n_in = '0;
    for (int k = 0; k < NCLIENT; k++) set_ops(k, 0, 0);
    tick();
    tick();
    chk("rst_ack", ack, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_busy", busy, 0);
    nrst = 1'b1;
    tick();

    // Single client, 3**5.
    run_job(0, 16'd3, 5);
    chk("t1_243", result, 243);

    // Edge operands.
    run_job(1, 16'd7, 0);
    chk("t2_n0", result, 1);
    run_job(2, 16'd0, 4);
    chk("t2_x0", result, 0);
    run_job(3, 16'd2, 16);
    chk("t2_wrap", result, 0);

    // All clients requesting after reset: rotation 1,2,3,0,1.
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    model_rr = 0;
    for (int k = 0; k < NCLIENT; k++) set_ops(k, W'(k + 2), k + 3);
    req = '1;
    for (int j = 0; j < 5; j++) begin
      serve(0);
      chk("t3_order", model_rr, (j + 1) % NCLIENT);
    end
    req = '0;
    tick();
    tick();
    chk("t3_idle", busy, 0);

    // Reset in the middle of a long job.
    set_ops(1, 16'd5, 200);
    req[1] = 1'b1;
    wait_ack(g);
    chk("t4_grant", g, 1);
    req[1] = 1'b0;
    job_open = 1'b1;
    tick();
    tick();
    tick();
    nrst = 1'b0;
    tick();
    job_open = 1'b0;
    chk("t4_busy", busy, 0);
    chk("t4_result", result, 0);
    chk("t4_done", done, 0);
    nrst = 1'b1;
    model_rr = 0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done != 0) seen = 1'b1;
    end
    chk("t4_no_done", seen, 0);
    run_job(1, 16'd5, 200);

    // Client 2 re-requests right after its done while client 3 waits.
    set_ops(2, 16'd9, 3);
    req[2] = 1'b1;
    serve(1);
    set_ops(3, 16'd11, 7);
    set_ops(2, 16'd13, 6);
    req[2] = 1'b1;
    req[3] = 1'b1;
    serve(1);
    chk("t5_first", model_rr, 3);
    serve(1);
    chk("t5_second", model_rr, 2);
    tick();
    chk("t5_idle", busy, 0);

    // Randomized request sets.
    for (int r = 0; r < 12; r++) begin
      logic [NCLIENT-1:0] mask;
      mask = NCLIENT'($urandom_range(1, (1 << NCLIENT) - 1));
      for (int k = 0; k < NCLIENT; k++) begin
        if (mask[k]) begin
          int sx;
          int sn;
          logic [W-1:0] x;
          int n;
          sx = $urandom_range(0, 7);
          sn = $urandom_range(0, 5);
          x = (sx == 0) ? W'(0) : (sx == 1) ? W'(2) : W'($urandom);
          n = (sn == 0) ? 0 : (sn == 1) ? 255 : $urandom_range(1, 255);
          set_ops(k, x, n);
        end
      end
      req = mask;
      for (int j = 0; j < NCLIENT; j++) if (req != 0) serve(1);
    end
    tick();
    tick();
    chk("final_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
